// File: rtl/dm_lsu.sv
// dm_lsu: load/store initiator between the datapath and a word-wide data memory.
// Byte/half/word loads with sign/zero extension; sub-word stores use
// read-modify-write because the memory only writes whole words.
// Optional macro LSU_RANGE_CHECK_EN: flag addresses above the memory as errors.
module dm_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;

  state_t            state;
  logic              lat_we, lat_sign;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata, merge;
  logic              req_err, range_err;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_data, merge_data;

  // Memory side is driven purely from state and the latched request, so an
  // async reset drops mem_we in the same instant.
  assign req_ready = (state == IDLE);
  assign mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
  assign mem_we    = (state == WRITE) || (state == ACCESS && lat_we && lat_size == 2'b10);
  assign mem_din   = (state == WRITE) ? merge : lat_wdata;

`ifdef LSU_RANGE_CHECK_EN
  assign range_err = |req_addr[31:ADDR_W];
`else
  // Upper address bits are ignored: addresses alias modulo 2^ADDR_W.
  logic unused_addr;
  assign unused_addr = |req_addr[31:ADDR_W];
  assign range_err   = 1'b0;
`endif

  // Classify the incoming request: reserved size, misalignment or range.
  always_comb begin
    req_err = range_err;
    case (req_size)
      2'b01:   if (req_addr[0]) req_err = 1'b1;
      2'b10:   if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      2'b11:   req_err = 1'b1;
      default: ;
    endcase
  end

  // Lane select and extension for loads, lane insert for sub-word stores.
  always_comb begin
    lane_b     = mem_dout[{lat_addr[1:0], 3'b000} +: 8];
    lane_h     = mem_dout[{lat_addr[1], 4'b0000} +: 16];
    load_data  = mem_dout;
    merge_data = mem_dout;
    case (lat_size)
      2'b00: begin
        load_data = {{24{lat_sign & lane_b[7]}}, lane_b};
        merge_data[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
      end
      2'b01: begin
        load_data = {{16{lat_sign & lane_h[15]}}, lane_h};
        merge_data[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
      end
      default: ;
    endcase
  end

  // Request FSM: accept in IDLE, access memory, optional RMW write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      lat_we    <= 1'b0;
      lat_sign  <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      merge     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          lat_we    <= req_we;
          lat_sign  <= req_sign;
          lat_size  <= req_size;
          lat_addr  <= req_addr[ADDR_W-1:0];
          lat_wdata <= req_wdata;
          if (req_err) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!lat_we) begin
            rsp_rdata <= load_data;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else if (lat_size == 2'b10) begin
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            merge <= merge_data;
            state <= WRITE;
          end
        end
        WRITE: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
